dmem_pipelined: RTL and testbench
=================================

# dmem_pipelined

Parametrised data memory for the 32-bit MIPS datapath: word, halfword and byte loads and stores, with selectable sign or zero extension on sub-word loads. The block accepts requests on a valid/ready request channel and returns results on a valid/ready response channel after a programmable read latency. It sits between the MEM pipeline stage and the data-side storage, and lets the core stall on memory.

## Interface
- DEPTH_LOG2, 10, log2 of the number of 32-bit words; words are indexed by Address[DEPTH_LOG2+1:2].
- ADDR_W, 32, width of the byte address.
- LATENCY, 1, number of cycles from request accept to response valid; legal range 1..4.

- Clk  input  1  single clock; all state changes on the rising edge.
- Rst_n  input  1  asynchronous, active-low reset.
- ReqValid  input  1  request present.
- ReqReady  output  1  block can accept a request.
- ReqWrite  input  1  1 = store, 0 = load.
- ReqSize  input  2  01 = word, 10 = half, 11 = byte, 00 = reserved.
- ReqSigned  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- Address  input  ADDR_W  byte address.
- WriteData  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- RespValid  output  1  response present.
- RespReady  input  1  consumer takes the response.
- ReadData  output  32  extended load result; 0 for stores and faults.
- RespFault  output  1  request was misaligned or had a reserved size.

## Operation
- FSM states:
  - IDLE: ReqReady=1.
  - WAIT: latency counter running.
  - RESP: RespValid=1.
- Accept: ReqValid && ReqReady at a rising edge.
  - IDLE -> WAIT when LATENCY>1 and the counter loads LATENCY-2.
  - IDLE -> RESP directly when LATENCY=1.
- WAIT: decrement the counter each cycle. Go to RESP on the edge where the counter is 0.
- RESP: hold ReadData and RespFault stable until RespValid && RespReady at an edge, then go to IDLE.
- Only one request is outstanding at a time. ReqReady is 0 in WAIT and RESP.
- Stores commit to memory at the accept edge and touch only the addressed lanes:
  - word: all 32 bits.
  - half: [15:0] if Address[1]=0, else [31:16].
  - byte: lane Address[1:0].
- Loads sample memory at the accept edge. The lane is selected as for stores. The result is zero- or sign-extended to 32 bits according to ReqSigned. Word loads ignore ReqSigned.
- Address bits above DEPTH_LOG2+1 are ignored, so the address wraps modulo the depth.
- Misaligned or reserved requests (word with Address[1:0]!=0, half with Address[0]=1, size 00):
  - no memory write;
  - ReadData=0 and RespFault=1;
  - same latency as a normal request.
- Memory contents are not reset and are undefined until written.

## Timing
- Reset values: ReqReady=1, RespValid=0, ReadData=0, RespFault=0; FSM=IDLE; counter=0.
- Reset is asynchronous. Asserting it mid-operation aborts the outstanding request with no response. A store that was already accepted stays committed.
- RespValid rises LATENCY cycles after the accept edge.
- ReqReady returns high the cycle after the RespValid && RespReady edge.
- Maximum throughput is one request per LATENCY+1 cycles when RespReady is held high.
- A store followed by a load to the same word returns the new data, because requests are strictly serialised.
- Request inputs are ignored whenever ReqReady=0.

## Configuration
- DMEM_FAULT_EN defined:
  - misalignment and reserved-size detection as described in Operation.
- DMEM_FAULT_EN undefined:
  - RespFault is tied to 0;
  - word accesses ignore Address[1:0] and half accesses ignore Address[0] (forced alignment);
  - size 00 is treated as word;
  - all requests access memory.

## Test plan
- Reset, then store word 0xDEADBEEF at 0x10; load word 0x10 with LATENCY=1 -> RespValid one cycle after accept, ReadData=0xDEADBEEF, RespFault=0.
- Store byte 0x80 at 0x23, then load byte 0x23 with ReqSigned=1 -> 0xFFFFFF80; with ReqSigned=0 -> 0x00000080; other bytes of word 0x20 unchanged.
- Store half 0x8001 at 0x32, then load half 0x32 signed -> 0xFFFF8001; load word 0x30 -> upper half 0x8001, lower half unchanged.
- LATENCY=3, RespReady held low for 5 cycles -> RespValid asserted 3 cycles after accept, ReadData stable throughout, ReqReady=0 until the cycle after the handshake.
- With DMEM_FAULT_EN: store word at 0x42 -> RespFault=1, ReadData=0, word 0x40 unchanged. Without it: the same store writes word 0x40 and RespFault=0.
- Assert Rst_n low in WAIT -> RespValid=0 and ReqReady=1 immediately; no response appears after release; a store accepted before reset is readable afterwards.

Source files
------------

// File: rtl/dmem_pipelined.sv
// dmem_pipelined: data memory for the 32-bit MIPS datapath.
//
// Serves word, halfword and byte loads and stores over a valid/ready request
// channel and returns one response per request on a valid/ready response
// channel, LATENCY cycles after the request is accepted. Only one request is
// outstanding at a time, so a store followed by a load always sees the new
// data.
//
// Ports
//   Clk        in   clock, rising edge
//   Rst_n      in   asynchronous active-low reset
//   ReqValid   in   request present
//   ReqReady   out  block is idle and can accept a request
//   ReqWrite   in   1 = store, 0 = load
//   ReqSize    in   01 word, 10 half, 11 byte, 00 reserved
//   ReqSigned  in   sub-word loads: 1 = sign-extend, 0 = zero-extend
//   Address    in   byte address (wraps modulo the memory depth)
//   WriteData  in   right-aligned store data
//   RespValid  out  response present
//   RespReady  in   consumer takes the response
//   ReadData   out  extended load result; 0 for stores and faults
//   RespFault  out  misaligned or reserved-size request
//
// Configuration macro DMEM_FAULT_EN:
//   defined   - misaligned / reserved-size requests are flagged, not executed
//   undefined - RespFault tied to 0, low address bits ignored (forced
//               alignment), size 00 handled as a word access
//
// Memory contents are not reset.

module dmem_pipelined #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LATENCY    = 1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic              ReqWrite,
    input  logic [1:0]        ReqSize,
    input  logic              ReqSigned,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       WriteData,
    output logic              RespValid,
    input  logic              RespReady,
    output logic [31:0]       ReadData,
    output logic              RespFault
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;

    // Counter value loaded on accept; WAIT lasts CntLoad+1 cycles.
    localparam logic [1:0] CntLoad = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

    localparam logic [1:0] SizeWord = 2'b01;
    localparam logic [1:0] SizeHalf = 2'b10;
    localparam logic [1:0] SizeByte = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;

    logic [31:0] mem_q [Depth];

    logic [DEPTH_LOG2-1:0] word_idx;
    logic [1:0]            lane;
    logic                  unused_addr;

    logic        req_accept;
    logic        req_fault;
    logic        mem_we;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic [31:0] rd_word;
    logic [15:0] rd_half;
    logic [7:0]  rd_byte;
    logic [31:0] load_data;

    assign word_idx    = Address[DEPTH_LOG2+1:2];
    assign lane        = Address[1:0];
    // Upper address bits are deliberately dropped so accesses wrap.
    assign unused_addr = ^Address[ADDR_W-1:DEPTH_LOG2+2];

    assign req_accept = ReqValid && (state_q == StIdle);

    // ------------------------------------------------------------------
    // Request classification
    // ------------------------------------------------------------------
`ifdef DMEM_FAULT_EN
    always_comb begin
        case (ReqSize)
            SizeWord: req_fault = (lane != 2'b00);
            SizeHalf: req_fault = lane[0];
            SizeByte: req_fault = 1'b0;
            default:  req_fault = 1'b1;
        endcase
    end
`else
    assign req_fault = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Store lane steering: replicate the right-aligned data to every lane
    // and let the byte enables pick the addressed ones.
    // ------------------------------------------------------------------
    always_comb begin
        wr_be   = 4'b1111;
        wr_data = WriteData;
        case (ReqSize)
            SizeHalf: begin
                wr_be   = lane[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{WriteData[15:0]}};
            end
            SizeByte: begin
                wr_be   = 4'b0001 << lane;
                wr_data = {4{WriteData[7:0]}};
            end
            default: begin
                // Word, and size 00 when fault detection is disabled.
                wr_be   = 4'b1111;
                wr_data = WriteData;
            end
        endcase
    end

    assign mem_we = req_accept && ReqWrite && !req_fault;

    always_ff @(posedge Clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem_q[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Load lane selection and extension
    // ------------------------------------------------------------------
    assign rd_word = mem_q[word_idx];
    assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
    assign rd_byte = 8'(rd_word >> {lane, 3'b000});

    always_comb begin
        case (ReqSize)
            SizeHalf: load_data = {{16{ReqSigned & rd_half[15]}}, rd_half};
            SizeByte: load_data = {{24{ReqSigned & rd_byte[7]}}, rd_byte};
            default:  load_data = rd_word;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        fault_d = fault_q;

        case (state_q)
            StIdle: begin
                if (req_accept) begin
                    // Result is captured at accept; it is held until taken.
                    rdata_d = (ReqWrite || req_fault) ? 32'h0 : load_data;
                    fault_d = req_fault;
                    if (LATENCY > 1) begin
                        state_d = StWait;
                        cnt_d   = CntLoad;
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 2'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            StResp: begin
                if (RespReady) begin
                    state_d = StIdle;
                    rdata_d = 32'h0;
                    fault_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 2'd0;
            rdata_q <= 32'h0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    assign ReqReady  = (state_q == StIdle);
    assign RespValid = (state_q == StResp);
    assign ReadData  = rdata_q;
    assign RespFault = fault_q;

endmodule

// File: tb/tb_dmem_pipelined.sv
module tb_dmem_pipelined;

    localparam logic [1:0] SzW = 2'b01;
    localparam logic [1:0] SzH = 2'b10;
    localparam logic [1:0] SzB = 2'b11;
    localparam logic [1:0] SzR = 2'b00;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] address;
    logic [31:0] wdata;
    logic        resp_ready;

    logic        req_valid1, req_ready1, resp_valid1, resp_fault1;
    logic [31:0] read_data1;
    logic        req_valid3, req_ready3, resp_valid3, resp_fault3;
    logic [31:0] read_data3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_pipelined #(.DEPTH_LOG2(10), .ADDR_W(32), .LATENCY(1)) u_dut1 (
        .Clk       (clk),
        .Rst_n     (rst_n),
        .ReqValid  (req_valid1),
        .ReqReady  (req_ready1),
        .ReqWrite  (req_write),
        .ReqSize   (req_size),
        .ReqSigned (req_signed),
        .Address   (address),
        .WriteData (wdata),
        .RespValid (resp_valid1),
        .RespReady (resp_ready),
        .ReadData  (read_data1),
        .RespFault (resp_fault1)
    );

    dmem_pipelined #(.DEPTH_LOG2(10), .ADDR_W(32), .LATENCY(3)) u_dut3 (
        .Clk       (clk),
        .Rst_n     (rst_n),
        .ReqValid  (req_valid3),
        .ReqReady  (req_ready3),
        .ReqWrite  (req_write),
        .ReqSize   (req_size),
        .ReqSigned (req_signed),
        .Address   (address),
        .WriteData (wdata),
        .RespValid (resp_valid3),
        .RespReady (resp_ready),
        .ReadData  (read_data3),
        .RespFault (resp_fault3)
    );

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_fault;
    } vec_t;

    localparam int NumVecs = 20;
    vec_t vecs [NumVecs];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one request to the selected DUT (1 or 3); called at a negedge
    // with the DUT idle. Returns the response and the observed latency.
    task automatic req(input int sel, input logic w, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic f, output int lat);
        req_write  = w;
        req_size   = sz;
        req_signed = sgn;
        address    = a;
        wdata      = wd;
        if (sel == 3) req_valid3 = 1'b1;
        else          req_valid1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid1 = 1'b0;
        req_valid3 = 1'b0;
        lat = 1;
        while (!((sel == 3) ? resp_valid3 : resp_valid1) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = (sel == 3) ? read_data3 : read_data1;
        f  = (sel == 3) ? resp_fault3 : resp_fault1;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    logic [31:0] rd;
    logic        f;
    int          lat;
    int          stray;

    initial begin
        rst_n      = 1'b0;
        req_valid1 = 1'b0;
        req_valid3 = 1'b0;
        req_write  = 1'b0;
        req_size   = SzW;
        req_signed = 1'b0;
        address    = 32'h0;
        wdata      = 32'h0;
        resp_ready = 1'b0;

        //             wr    size sgn   addr         wdata         exp_rd        fault
        vecs[0]  = '{1'b1, SzW, 1'b0, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, SzW, 1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, SzW, 1'b0, 32'h20,   32'h11223344, 32'h0,        1'b0};
        vecs[3]  = '{1'b1, SzB, 1'b0, 32'h23,   32'h00000080, 32'h0,        1'b0};
        vecs[4]  = '{1'b0, SzB, 1'b1, 32'h23,   32'h0,        32'hFFFFFF80, 1'b0};
        vecs[5]  = '{1'b0, SzB, 1'b0, 32'h23,   32'h0,        32'h00000080, 1'b0};
        vecs[6]  = '{1'b0, SzW, 1'b0, 32'h20,   32'h0,        32'h80223344, 1'b0};
        vecs[7]  = '{1'b1, SzW, 1'b0, 32'h30,   32'hAABBCCDD, 32'h0,        1'b0};
        vecs[8]  = '{1'b1, SzH, 1'b0, 32'h32,   32'h00008001, 32'h0,        1'b0};
        vecs[9]  = '{1'b0, SzH, 1'b1, 32'h32,   32'h0,        32'hFFFF8001, 1'b0};
        vecs[10] = '{1'b0, SzW, 1'b0, 32'h30,   32'h0,        32'h8001CCDD, 1'b0};
        vecs[11] = '{1'b0, SzH, 1'b0, 32'h30,   32'h0,        32'h0000CCDD, 1'b0};
        vecs[12] = '{1'b0, SzB, 1'b1, 32'h31,   32'h0,        32'hFFFFFFCC, 1'b0};
        vecs[13] = '{1'b1, SzW, 1'b0, 32'h40,   32'h5A5A5A5A, 32'h0,        1'b0};
        vecs[16] = '{1'b1, SzW, 1'b0, 32'h1050, 32'hCAFEF00D, 32'h0,        1'b0};
        vecs[17] = '{1'b0, SzW, 1'b0, 32'h50,   32'h0,        32'hCAFEF00D, 1'b0};
`ifdef DMEM_FAULT_EN
        vecs[14] = '{1'b1, SzW, 1'b0, 32'h42,   32'h12345678, 32'h0,        1'b1};
        vecs[15] = '{1'b0, SzW, 1'b0, 32'h40,   32'h0,        32'h5A5A5A5A, 1'b0};
        vecs[18] = '{1'b0, SzH, 1'b0, 32'h51,   32'h0,        32'h0,        1'b1};
        vecs[19] = '{1'b0, SzR, 1'b0, 32'h50,   32'h0,        32'h0,        1'b1};
`else
        vecs[14] = '{1'b1, SzW, 1'b0, 32'h42,   32'h12345678, 32'h0,        1'b0};
        vecs[15] = '{1'b0, SzW, 1'b0, 32'h40,   32'h0,        32'h12345678, 1'b0};
        vecs[18] = '{1'b0, SzH, 1'b0, 32'h51,   32'h0,        32'h0000F00D, 1'b0};
        vecs[19] = '{1'b0, SzR, 1'b0, 32'h50,   32'h0,        32'hCAFEF00D, 1'b0};
`endif

        // Reset values.
        @(negedge clk);
        check("rst_req_ready1",  32'(req_ready1),  32'h1);
        check("rst_resp_valid1", 32'(resp_valid1), 32'h0);
        check("rst_read_data1",  read_data1,       32'h0);
        check("rst_resp_fault1", 32'(resp_fault1), 32'h0);
        check("rst_req_ready3",  32'(req_ready3),  32'h1);
        check("rst_resp_valid3", 32'(resp_valid3), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven vectors on the LATENCY=1 instance.
        for (int i = 0; i < NumVecs; i++) begin
            check($sformatf("v%0d_req_ready", i), 32'(req_ready1), 32'h1);
            req(1, vecs[i].wr, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
                rd, f, lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'd1);
            check($sformatf("v%0d_read_data", i), rd, vecs[i].exp_rd);
            check($sformatf("v%0d_fault", i), 32'(f), 32'(vecs[i].exp_fault));
        end

        // LATENCY=3: store, then a load held by RespReady low for 5 cycles
        // while a stray store is presented (must be ignored).
        req(3, 1'b1, SzW, 1'b0, 32'h60, 32'h0BADC0DE, rd, f, lat);
        check("l3_store_latency", 32'(lat), 32'd3);
        req_write  = 1'b0;
        req_size   = SzW;
        address    = 32'h60;
        req_valid3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_write = 1'b1;
        wdata     = 32'hFFFFFFFF;
        for (int k = 1; k <= 7; k++) begin
            if (k < 3) begin
                check($sformatf("l3_k%0d_resp_valid", k), 32'(resp_valid3), 32'h0);
            end else begin
                check($sformatf("l3_k%0d_resp_valid", k), 32'(resp_valid3), 32'h1);
                check($sformatf("l3_k%0d_read_data", k), read_data3, 32'h0BADC0DE);
            end
            check($sformatf("l3_k%0d_req_ready", k), 32'(req_ready3), 32'h0);
            if (k < 7) @(negedge clk);
        end
        req_valid3 = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        check("l3_after_hs_req_ready",  32'(req_ready3),  32'h1);
        check("l3_after_hs_resp_valid", 32'(resp_valid3), 32'h0);
        req(3, 1'b0, SzW, 1'b0, 32'h60, 32'h0, rd, f, lat);
        check("l3_stray_ignored", rd, 32'h0BADC0DE);
        check("l3_load_latency", 32'(lat), 32'd3);

        // Reset while in WAIT: request aborted, store stays committed.
        req_write  = 1'b1;
        req_size   = SzW;
        address    = 32'h70;
        wdata      = 32'h13572468;
        req_valid3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid3 = 1'b0;
        check("rw_in_wait_req_ready", 32'(req_ready3), 32'h0);
        rst_n = 1'b0;
        #1;
        check("rw_rst_resp_valid", 32'(resp_valid3), 32'h0);
        check("rw_rst_req_ready",  32'(req_ready3),  32'h1);
        check("rw_rst_read_data",  read_data3,       32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (resp_valid3) stray++;
        end
        check("rw_no_response", 32'(stray), 32'd0);
        req(3, 1'b0, SzW, 1'b0, 32'h70, 32'h0, rd, f, lat);
        check("rw_store_kept", rd, 32'h13572468);
        check("rw_load_fault", 32'(f), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
